// File: rtl/vr_pkg.sv
// Shared types and constants for the valid/ready master.
//   vr_state_e : master FSM state (VR_IDLE, VR_SEND)
//   VR_CNT_W   : width of the optional completed-transfer counter
package vr_pkg;

  typedef enum logic [0:0] {
    VR_IDLE = 1'b0,
    VR_SEND = 1'b1
  } vr_state_e;

  localparam int unsigned VR_CNT_W = 16;

endpackage

// File: rtl/vr_fifo.sv
// Synchronous FIFO feeding the master output register.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push       write request with wdata (ignored while full)
//   pop        read request (ignored while empty); rdata shows the head
//   full       DEPTH words held, from current occupancy
//   empty      no words held
module vr_fifo #(
  parameter int unsigned L     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [L-1:0] wdata,
  input  logic         pop,
  output logic [L-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q;
  logic [L-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full    = (occ_q == (AW + 1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/vr_master.sv
// Transmitter end of the valid/ready point-to-point bus.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   wen, wdata   producer write port (dropped while full)
//   full         FIFO holds DEPTH words
//   valid        data_out holds a word on offer (registered)
//   ready        receiver accept; a transfer is valid && ready at a rising edge
//   data_out     registered word under offer
//   busy         valid high or FIFO non-empty
//   xfer_cnt     completed-transfer count, only when VR_MASTER_COUNT_EN is defined
module vr_master
  import vr_pkg::*;
#(
  parameter int unsigned L     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [L-1:0]        wdata,
  output logic                full,
  output logic                valid,
  input  logic                ready,
  output logic [L-1:0]        data_out,
  output logic                busy
`ifdef VR_MASTER_COUNT_EN
  ,
  output logic [VR_CNT_W-1:0] xfer_cnt
`endif
);

  vr_state_e    state_q, state_d;
  logic [L-1:0] data_q, data_d;
  logic [L-1:0] head;
  logic         empty;
  logic         pop;
  logic         xfer;

  vr_fifo #(
    .L     (L),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wen),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign valid    = (state_q == VR_SEND);
  assign data_out = data_q;
  assign xfer     = valid && ready;
  assign busy     = valid || !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VR_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VR_IDLE: if (!empty) state_d = VR_SEND;
      VR_SEND: if (xfer && empty) state_d = VR_IDLE;
      default: state_d = VR_IDLE;
    endcase
  end

  // Emptiness is sampled before this edge's push, so a word written while
  // draining is offered one cycle later rather than bypassing the FIFO.
  always_comb begin
    pop    = 1'b0;
    data_d = data_q;
    unique case (state_q)
      VR_IDLE: pop = !empty;
      VR_SEND: pop = xfer && !empty;
      default: pop = 1'b0;
    endcase
    if (pop) data_d = head;
  end

`ifdef VR_MASTER_COUNT_EN
  logic [VR_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 1'b1;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_vr_master.sv
module tb_vr_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen;
  logic [7:0] wdata;
  logic       full;
  logic       valid;
  logic       ready;
  logic [7:0] data_out;
  logic       busy;
`ifdef VR_MASTER_COUNT_EN
  logic [15:0] xfer_cnt;
`endif

  int errors = 0;
  int checks = 0;

  vr_master #(
    .L     (8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .wdata    (wdata),
    .full     (full),
    .valid    (valid),
    .ready    (ready),
    .data_out (data_out),
    .busy     (busy)
`ifdef VR_MASTER_COUNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wen = 1'b0; wdata = '0; ready = 1'b0;
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ready = 1'b1; wen = 1'b1; wdata = 8'hA5;
    tick();
    wen = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_lat1_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_lat1_busy got=%b exp=1", busy); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_offer_valid got=%b exp=1", valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_offer_data got=%h exp=a5", data_out); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got=%b exp=0", valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_done_data got=%h exp=a5", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_hold();
    ready = 1'b0;
    wen = 1'b1; wdata = 8'h11; tick();
    wdata = 8'h22; tick();
    wdata = 8'h33; tick();
    wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, valid); end
      checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL hold_data cyc=%0d got=%h exp=11", i, data_out); end
      tick();
    end
    ready = 1'b1;
    checks++; if (data_out !== 8'h11 || valid !== 1'b1) begin errors++; $display("FAIL b2b_w0 got=%b/%h exp=1/11", valid, data_out); end
    tick();
    checks++; if (data_out !== 8'h22 || valid !== 1'b1) begin errors++; $display("FAIL b2b_w1 got=%b/%h exp=1/22", valid, data_out); end
    tick();
    checks++; if (data_out !== 8'h33 || valid !== 1'b1) begin errors++; $display("FAIL b2b_w2 got=%b/%h exp=1/33", valid, data_out); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", valid); end
  endtask

  // 01 is loaded into the output register, 02..05 fill the FIFO, 06 is dropped.
  task automatic test_full();
    ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wen = 1'b1; wdata = 8'(i);
      tick();
      if (i == 4) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", full); end
      end
      if (i == 5) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got=%b exp=1", full); end
      end
    end
    wen = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_hold got=%b exp=1", full); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL full_head got=%h exp=01", data_out); end
    ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (valid !== 1'b1 || data_out !== 8'(k)) begin
        errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", k, valid, data_out, 8'(k));
      end
      tick();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_dropped_valid got=%b exp=0", valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear got=%b exp=0", full); end
  endtask

  task automatic test_toggle();
    logic [7:0] got [8];
    int n = 0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = 8'h10 + 8'(i);
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ready = (i % 2 == 0);
      if (valid && ready) begin
        if (n < 8) got[n] = data_out;
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL toggle_count got=%0d exp=4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < n && got[k] !== 8'h10 + 8'(k)) begin
        errors++; $display("FAIL toggle_word%0d got=%h exp=%h", k, got[k], 8'h10 + 8'(k));
      end
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL toggle_end_valid got=%b exp=0", valid); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    wen = 1'b1; wdata = 8'hAA; tick();
    wdata = 8'hBB; tick();
    wdata = 8'hCC; tick();
    wen = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h exp=00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    #2;
    rst = 1'b1;
    tick();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle%0d got=%b/%b exp=0/0", i, valid, busy); end
    end
    wen = 1'b1; wdata = 8'h77; tick();
    wen = 1'b0; tick();
    checks++; if (valid !== 1'b1 || data_out !== 8'h77) begin errors++; $display("FAIL rmid_new got=%b/%h exp=1/77", valid, data_out); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_new_done got=%b exp=0", valid); end
  endtask

`ifdef VR_MASTER_COUNT_EN
  task automatic test_count();
    #2; rst = 1'b0; #3; rst = 1'b1;
    tick();
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", xfer_cnt); end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = 8'(i + 1); tick();
    end
    wen = 1'b0;
    repeat (4) tick();
    checks++; if (xfer_cnt !== 16'd5) begin errors++; $display("FAIL cnt_five got=%0d exp=5", xfer_cnt); end
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    checks++; if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload got=%h exp=ffff", xfer_cnt); end
    wen = 1'b1; wdata = 8'h5A; tick();
    wen = 1'b0;
    repeat (3) tick();
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", xfer_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_full();
    test_toggle();
    test_reset_mid();
`ifdef VR_MASTER_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vr_master.md
# vr_master

Transmitter end of the team's valid/ready point-to-point bus. Accepts words from a local producer through a write port, buffers them in a small FIFO, and presents them one at a time on `valid`/`data_out` to a downstream receiver, holding each word stable until `ready` accepts it. Sits between a data source (register bank, DMA, test generator) and any bus receiver.

## Interface
- `L`, 8, data width in bits.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wen`  in  1  producer write strobe.
- `wdata`  in  L  producer write data, sampled when `wen && !full`.
- `full`  out  1  FIFO holds `DEPTH` words; combinational from occupancy.
- `valid`  out  1  registered; `data_out` holds a word offered to the receiver.
- `ready`  in  1  receiver accept; may be high or low independent of `valid`.
- `data_out`  out  L  registered word under offer.
- `busy`  out  1  `valid` high or FIFO non-empty.
- `xfer_cnt`  out  16  completed-transfer count; present only with `VR_MASTER_COUNT_EN`.

## Operation
- Reset values: `valid`=0, `data_out`=0, `full`=0, `busy`=0, `xfer_cnt`=0, FIFO empty, state IDLE.
- Write: `wen && !full` pushes `wdata`. `wen` while full is dropped silently, even if a pop occurs the same cycle (`full` uses current occupancy).
- Transfer: a word transfers at a rising edge where `valid && ready`.
- FSM, two states:
  - IDLE (`valid`=0): FIFO non-empty → pop head into `data_out`, `valid`←1, go SEND. Else stay.
  - SEND (`valid`=1): no transfer → hold `valid` and `data_out` unchanged, stay. Transfer and FIFO non-empty → pop next word into `data_out`, stay SEND (back-to-back). Transfer and FIFO empty → `valid`←0, `data_out` holds last value, go IDLE.
- FIFO occupancy checked before this edge's push; a word written in the same cycle the FIFO drains is offered on a later cycle.
- `valid` never deasserts without a transfer except on reset; `data_out` never changes while `valid && !ready`.
- Word order on the bus equals write order; no loss except writes while full.
- Occupancy counter width `$clog2(DEPTH)+1`; pointers `$clog2(DEPTH)` bits, natural wrap.

## Timing
- Latency `wen` → `valid`: 2 cycles when IDLE and FIFO empty (edge N pushes, edge N+1 loads output).
- Throughput: one word per cycle while FIFO non-empty and `ready` held high.
- Reset asserted mid-transfer: `valid` falls immediately (async), buffered words discarded; first offer after reset release needs a new write.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged.

## Configuration
- `VR_MASTER_COUNT_EN` defined: `xfer_cnt` port exists; increments by 1 per transfer, wraps 0xFFFF→0, cleared by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Package `vr_pkg`: state enum typedef (`VR_IDLE`, `VR_SEND`), `VR_CNT_W` = 16.
- Sub-module `vr_fifo`: synchronous FIFO (push/pop/full/empty/head data), instantiated once; FSM and output register in `vr_master`.

## Test plan
- Reset then write 0xA5 with `ready`=1 → `valid` high 2 cycles later with `data_out`=0xA5, transfer next edge, `valid` low after.
- Write 0x11,0x22,0x33 with `ready`=0 for 6 cycles → `data_out`=0x11 stable, `valid`=1 throughout; raise `ready` → 0x11,0x22,0x33 on consecutive cycles, then `valid`=0.
- With `ready`=0 write DEPTH+2 words 0x01..0x06 (DEPTH=4) → `full`=1 after FIFO fills; accepted words transfer in order when `ready` rises; dropped writes never appear.
- Toggle `ready` 1,0,1,0 while streaming 0x10..0x13 → each word transfers exactly once, no duplicate or skip.
- Pull `rst` low while `valid`=1 and 2 words buffered → `valid`=0, `data_out`=0, `busy`=0 immediately; after release no transfer until new write.
- With `VR_MASTER_COUNT_EN`: 5 transfers → `xfer_cnt`=5; preload 0xFFFF by forcing, one transfer → 0.
